fifo_drain_arbiter: RTL and testbench
=====================================

Name: fifo_drain_arbiter

Overview:
- Read-side scheduler that drains NUM_FIFOS asynchronous FIFOs sharing one read clock into a single valid/ready output stream.
- Watches each FIFO's empty flag and issues single-cycle read enables. Grants rotate round-robin, with up to BURST_LEN words taken per grant.
- Captures each FIFO's registered read data and presents it with a channel tag.
- Sits between the FIFO read ports and the downstream consumer.

Parameters:
- NUM_FIFOS, 4, number of FIFOs/requesters (2..16).
- DATA_WIDTH, 8, width of each FIFO data word.
- CH_WIDTH, 2, width of channel index; must satisfy 2**CH_WIDTH >= NUM_FIFOS.
- BURST_LEN, 4, maximum words read from one FIFO per grant (>=1).

Ports:
- RClk  input  1  read-domain clock; all logic is on its rising edge.
- PresetFull  input  1  reset, asynchronous, active-high.
- Enable_in  input  NUM_FIFOS  per-channel enable mask; 0 excludes that channel from arbitration.
- Empty_in  input  NUM_FIFOS  FIFO empty flags, synchronous to RClk.
- Data_in  input  NUM_FIFOS*DATA_WIDTH  FIFO read data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. Each FIFO updates its data on the RClk edge where its read enable is high.
- ReadEn_out  output  NUM_FIFOS  one-hot or zero FIFO read enables.
- Data_out  output  DATA_WIDTH  captured word.
- Channel_out  output  CH_WIDTH  source channel of Data_out.
- Valid_out  output  1  Data_out/Channel_out valid.
- Ready_in  input  1  consumer accepts the word when Valid_out & Ready_in.
- Busy_out  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, PresetFull=1):
  - State and counter: state=IDLE, gnt=0, ptr=0, beat=0.
  - Outputs: ReadEn_out=0, Data_out=0, Channel_out=0, Valid_out=0, Busy_out=0.
  - Reset mid-operation aborts any word in flight; nothing is replayed.
- Request vector: req = ~Empty_in & Enable_in.
- FSM states: IDLE, READ, LOAD, SEND.
- IDLE:
  - If req != 0, gnt <= first set req index searching ptr, ptr+1, ... mod NUM_FIFOS; beat <= 0; go READ.
  - Otherwise stay in IDLE.
- READ:
  - ReadEn_out = one-hot(gnt), decoded combinationally from the state, only if Empty_in[gnt]=0 and Enable_in[gnt]=1.
  - If the read was issued, go LOAD.
  - If it was suppressed (flag became empty, e.g. FIFO clear, or channel disabled), ReadEn_out stays 0, ptr <= gnt+1 mod N, go IDLE; no word is produced.
- LOAD:
  - Data_out <= Data_in slice gnt; Channel_out <= gnt; Valid_out <= 1; go SEND.
- SEND:
  - Valid_out=1; Data_out and Channel_out are held stable until accepted.
  - On Ready_in=1: Valid_out <= 0 and beat <= beat+1.
    - If beat+1 < BURST_LEN and req[gnt]=1: go READ, same gnt (burst continues).
    - Else: ptr <= gnt+1 mod N, go IDLE.
  - While Ready_in=0: no ReadEn_out is issued for any channel.
- Latency and throughput:
  - Request seen in IDLE → ReadEn_out next cycle → Valid_out two cycles after ReadEn_out.
  - Minimum 3 cycles per word within a burst with Ready_in held high; 4 cycles when re-arbitrating through IDLE.
- Invariants:
  - ReadEn_out is never multi-hot.
  - ReadEn_out is never asserted to a channel whose Empty_in=1.
  - At most one word is outstanding.
- Wrap-around: ptr and the search wrap modulo NUM_FIFOS. Indices >= NUM_FIFOS are never granted.
- Enable_in changes take effect at the next READ or arbitration decision. A word already captured is still delivered.
- BURST_LEN=1 gives pure round-robin, one word per grant.

Test Plan:
1. Reset and idle: assert PresetFull mid-SEND -> Valid_out, ReadEn_out, Busy_out all 0 immediately. With Empty_in=4'b1111 after release, outputs stay 0 for 20 cycles.
2. Single word: Empty_in=4'b1110, ch0 data 8'hA5, Ready_in=1 -> ReadEn_out=4'b0001 for exactly one cycle. Two cycles later Valid_out=1, Data_out=8'hA5, Channel_out=0.
3. Burst limit: ch1 holds 6 words 8'h10..8'h15, other channels empty.
   - Required: 4 reads (8'h10..8'h13), return to IDLE, then a new grant to ch1 for 8'h14, 8'h15.
   - Required: ReadEn_out[1] stops once Empty_in[1]=1.
4. Round-robin: all four channels hold 2 words, BURST_LEN=1 -> Channel_out sequence 0,1,2,3,0,1,2,3.
5. Backpressure: hold Ready_in=0 for 5 cycles while Valid_out=1 with 8'h3C -> Data_out stays 8'h3C, ReadEn_out=0 throughout. The word is accepted on the first Ready_in=1 cycle.
6. Suppression and mask:
   - Enable_in=4'b1011 with all channels non-empty -> ch2 is never granted.
   - Force Empty_in[gnt]=1 during READ -> no ReadEn_out, no Valid_out, FSM returns to IDLE and ptr advances.

Source files
------------

// File: rtl/fifo_drain_arbiter_if.sv
// Read-side bundle between the FIFO read ports, the drain arbiter and the downstream consumer.
// The arbiter takes the master modport; FIFOs and consumer sit behind the slave modport.
interface fifo_drain_arbiter_if #(
    parameter int unsigned NUM_FIFOS  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CH_WIDTH   = 2
);
    logic [NUM_FIFOS-1:0]            Enable_in;
    logic [NUM_FIFOS-1:0]            Empty_in;
    logic [NUM_FIFOS*DATA_WIDTH-1:0] Data_in;
    logic [NUM_FIFOS-1:0]            ReadEn_out;
    logic [DATA_WIDTH-1:0]           Data_out;
    logic [CH_WIDTH-1:0]             Channel_out;
    logic                            Valid_out;
    logic                            Ready_in;
    logic                            Busy_out;

    modport master (
        input  Enable_in,
        input  Empty_in,
        input  Data_in,
        input  Ready_in,
        output ReadEn_out,
        output Data_out,
        output Channel_out,
        output Valid_out,
        output Busy_out
    );

    modport slave (
        output Enable_in,
        output Empty_in,
        output Data_in,
        output Ready_in,
        input  ReadEn_out,
        input  Data_out,
        input  Channel_out,
        input  Valid_out,
        input  Busy_out
    );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain scheduler: issues single-cycle FIFO reads, up to BURST_LEN per grant,
// and forwards each captured word with its channel tag on a valid/ready stream.
module fifo_drain_arbiter #(
    parameter int unsigned NUM_FIFOS  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CH_WIDTH   = 2,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                RClk,
    input  logic                PresetFull,
    fifo_drain_arbiter_if.master bus
);
    localparam int unsigned NumSlots = 2 ** CH_WIDTH;
    localparam int unsigned BeatW    = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StLoad,
        StSend
    } state_e;

    state_e                state_q, state_d;
    logic [CH_WIDTH-1:0]   gnt_q, gnt_d;
    logic [CH_WIDTH-1:0]   ptr_q, ptr_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [BeatW-1:0]      beat_next;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CH_WIDTH-1:0]   chan_q, chan_d;
    logic                  valid_q, valid_d;

    logic [NumSlots-1:0]   req_pad;
    logic [DATA_WIDTH-1:0] slot_data [NumSlots];
    logic                  pick_found;
    logic [CH_WIDTH-1:0]   pick_idx;
    logic                  read_issue;
    logic [NUM_FIFOS-1:0]  read_en_vec;

    function automatic logic [CH_WIDTH-1:0] inc_wrap(input logic [CH_WIDTH-1:0] idx);
        if (idx == CH_WIDTH'(NUM_FIFOS - 1)) begin
            return '0;
        end
        return idx + CH_WIDTH'(1);
    endfunction

    // Pad to the full index space so a CH_WIDTH-bit grant always selects a defined slot.
    assign req_pad = NumSlots'(~bus.Empty_in & bus.Enable_in);

    for (genvar i = 0; i < int'(NumSlots); i++) begin : g_slot
        if (i < int'(NUM_FIFOS)) begin : g_used
            assign slot_data[i] = bus.Data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign slot_data[i] = '0;
        end
    end

    // First requesting channel at or after ptr, wrapping modulo NUM_FIFOS.
    always_comb begin
        logic [CH_WIDTH:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            cand = {1'b0, ptr_q} + (CH_WIDTH + 1)'(k);
            if (cand >= (CH_WIDTH + 1)'(NUM_FIFOS)) begin
                cand = cand - (CH_WIDTH + 1)'(NUM_FIFOS);
            end
            if (!pick_found && req_pad[cand[CH_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CH_WIDTH-1:0];
            end
        end
    end

    assign beat_next = beat_q + BeatW'(1);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        data_d     = data_q;
        chan_d     = chan_q;
        valid_d    = valid_q;
        read_issue = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    beat_d  = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                // Recheck the granted channel: it may have been cleared or disabled meanwhile.
                if (req_pad[gnt_q]) begin
                    read_issue = 1'b1;
                    state_d    = StLoad;
                end else begin
                    ptr_d   = inc_wrap(gnt_q);
                    state_d = StIdle;
                end
            end
            StLoad: begin
                data_d  = slot_data[gnt_q];
                chan_d  = gnt_q;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (bus.Ready_in) begin
                    valid_d = 1'b0;
                    beat_d  = beat_next;
                    if ((32'(beat_next) < BURST_LEN) && req_pad[gnt_q]) begin
                        state_d = StRead;
                    end else begin
                        ptr_d   = inc_wrap(gnt_q);
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        read_en_vec = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            read_en_vec[i] = read_issue && (gnt_q == CH_WIDTH'(i));
        end
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ReadEn_out  = read_en_vec;
    assign bus.Data_out    = data_q;
    assign bus.Channel_out = chan_q;
    assign bus.Valid_out   = valid_q;
    assign bus.Busy_out    = (state_q != StIdle);

    a_ren_onehot: assert property (@(posedge RClk) disable iff (PresetFull)
        $onehot0(bus.ReadEn_out));
    a_ren_nonempty: assert property (@(posedge RClk) disable iff (PresetFull)
        (bus.ReadEn_out & bus.Empty_in) == '0);
    a_one_outstanding: assert property (@(posedge RClk) disable iff (PresetFull)
        bus.Valid_out |-> (bus.ReadEn_out == '0));
    a_hold_stable: assert property (@(posedge RClk) disable iff (PresetFull)
        (bus.Valid_out && !bus.Ready_in) |=>
        (bus.Valid_out && $stable(bus.Data_out) && $stable(bus.Channel_out)));
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: a BURST_LEN=4 and a BURST_LEN=1 instance, each fed by
// behavioural FIFOs, checked against a transaction-level drain-order model.
module tb_fifo_drain_arbiter;
    localparam int NF    = 4;
    localparam int DW    = 8;
    localparam int CW    = 2;
    localparam int DEPTH = 64;

    logic RClk       = 1'b0;
    logic PresetFull = 1'b1;
    always #5 RClk = ~RClk;

    logic [NF-1:0]        en          [2];
    logic                 rdy         [2];
    logic [NF-1:0]        force_empty [2];
    logic [DW-1:0]        mem         [2][NF][DEPTH];
    logic [5:0]           wr          [2][NF];
    logic [NF-1:0][5:0]   rd_all      [2];
    logic [NF-1:0]        emp         [2];
    logic [NF-1:0]        ren         [2];
    logic [DW-1:0]        dout        [2];
    logic [CW-1:0]        chout       [2];
    logic                 vld         [2];
    logic                 busy        [2];

    int total = 0;
    int bad   = 0;
    int acc_cyc [$];
    int acc_ch  [$];
    logic [CW+DW-1:0] got_q [$];
    int n_reads;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [NF-1:0][5:0]  rd_ptr = '0;
        logic [NF-1:0][DW-1:0] rdata = '0;
        logic [NF-1:0]       fifo_empty;

        fifo_drain_arbiter_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .CH_WIDTH(CW)) bus ();

        fifo_drain_arbiter #(
            .NUM_FIFOS (NF),
            .DATA_WIDTH(DW),
            .CH_WIDTH  (CW),
            .BURST_LEN ((g == 0) ? 4 : 1)
        ) dut (
            .RClk      (RClk),
            .PresetFull(PresetFull),
            .bus       (bus)
        );

        always_comb begin
            for (int i = 0; i < NF; i++) fifo_empty[i] = (wr[g][i] == rd_ptr[i]);
        end

        assign bus.Enable_in = en[g];
        assign bus.Empty_in  = fifo_empty | force_empty[g];
        assign bus.Data_in   = rdata;
        assign bus.Ready_in  = rdy[g];
        assign rd_all[g]     = rd_ptr;
        assign emp[g]        = bus.Empty_in;
        assign ren[g]        = bus.ReadEn_out;
        assign dout[g]       = bus.Data_out;
        assign chout[g]      = bus.Channel_out;
        assign vld[g]        = bus.Valid_out;
        assign busy[g]       = bus.Busy_out;

        // Registered-output FIFO: the popped word appears on Data_in after the read edge.
        always @(posedge RClk) begin
            for (int i = 0; i < NF; i++) begin
                if (bus.ReadEn_out[i] && !fifo_empty[i]) begin
                    rdata[i]  <= mem[g][i][rd_ptr[i]];
                    rd_ptr[i] <= rd_ptr[i] + 6'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int ch, input logic [DW-1:0] d);
        mem[k][ch][wr[k][ch]] = d;
        wr[k][ch] = wr[k][ch] + 6'd1;
    endtask

    function automatic int fill(input int k, input int ch);
        return int'(6'(wr[k][ch] - rd_all[k][ch]));
    endfunction

    task automatic do_reset();
        @(negedge RClk);
        PresetFull = 1'b1;
        @(negedge RClk);
        PresetFull = 1'b0;
    endtask

    task automatic inv(input int k);
        check("ren_onehot0", 32'($countones(ren[k]) <= 1), 1);
        check("ren_to_empty", 32'(ren[k] & emp[k]), 0);
        check("ren_while_valid", 32'(vld[k] && (ren[k] != '0)), 0);
    endtask

    task automatic wait_vld(input int k, input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(negedge RClk);
            if (vld[k]) ok = 1'b1;
        end
    endtask

    // Accept the next n words with Ready held high.
    task automatic collect(input int k, input int n, input int lim);
        int c;
        got_q.delete();
        rdy[k] = 1'b1;
        c = 0;
        while (got_q.size() < n && c < lim) begin
            @(negedge RClk);
            c++;
            inv(k);
            if (vld[k]) got_q.push_back({chout[k], dout[k]});
        end
        check("collect_count", 32'(got_q.size()), 32'(n));
    endtask

    // Expected stream: starting from ptr 0, pick the next enabled non-empty FIFO in
    // circular order, take up to BURST_LEN words from it, move ptr past it, repeat.
    task automatic run_check(input int k, input string tag, input int rdy_pct, input int lim);
        logic [CW+DW-1:0] exp_q [$];
        int left [NF];
        int taken [NF];
        int p, g, bl, cyc;
        bit hold;
        logic [CW+DW-1:0] held, cur;
        bl = (k == 0) ? 4 : 1;
        for (int i = 0; i < NF; i++) begin
            left[i]  = en[k][i] ? fill(k, i) : 0;
            taken[i] = 0;
        end
        p = 0;
        forever begin
            g = -1;
            for (int j = 0; j < NF; j++) if (g < 0 && left[(p + j) % NF] > 0) g = (p + j) % NF;
            if (g < 0) break;
            for (int b = 0; b < bl && left[g] > 0; b++) begin
                exp_q.push_back({CW'(g), mem[k][g][6'(rd_all[k][g] + 6'(taken[g]))]});
                taken[g]++;
                left[g]--;
            end
            p = (g + 1) % NF;
        end
        acc_cyc.delete();
        acc_ch.delete();
        n_reads = 0;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        while ((exp_q.size() != 0 || busy[k]) && cyc < lim) begin
            @(negedge RClk);
            cyc++;
            rdy[k] = ($urandom_range(99) < 32'(rdy_pct));
            inv(k);
            n_reads += $countones(ren[k]);
            cur = {chout[k], dout[k]};
            if (hold) begin
                check({tag, "_hold_valid"}, 32'(vld[k]), 1);
                check({tag, "_hold_word"}, 32'(cur), 32'(held));
            end
            if (vld[k] && rdy[k]) begin
                if (exp_q.size() == 0) check({tag, "_extra_word"}, 32'(cur), 32'hFFFF_FFFF);
                else check({tag, "_word"}, 32'(cur), 32'(exp_q.pop_front()));
                acc_cyc.push_back(cyc);
                acc_ch.push_back(int'(chout[k]));
            end
            hold = vld[k] && !rdy[k];
            held = cur;
        end
        check({tag, "_drained_in_budget"}, 32'(cyc < lim), 1);
        rdy[k] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge RClk);
            check({tag, "_quiet_tail"}, 32'({vld[k], ren[k]}), 0);
        end
    endtask

    initial begin
        bit ok;
        for (int k = 0; k < 2; k++) begin
            en[k]          = '1;
            rdy[k]         = 1'b0;
            force_empty[k] = '0;
            for (int i = 0; i < NF; i++) wr[k][i] = '0;
        end
        do_reset();

        // Reset mid-SEND, then quiet idle.
        push(0, 2, 8'h77);
        wait_vld(0, 10, ok);
        check("rst_valid_seen", 32'(ok), 1);
        #2 PresetFull = 1'b1;
        #1;
        check("rst_outputs", 32'({vld[0], busy[0], ren[0]}), 0);
        check("rst_data_chan", 32'({dout[0], chout[0]}), 0);
        @(negedge RClk);
        PresetFull = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge RClk);
            check("idle_after_reset", 32'({vld[0], busy[0], ren[0], vld[1], busy[1], ren[1]}), 0);
        end

        // Single word latency.
        rdy[0] = 1'b1;
        push(0, 0, 8'hA5);
        @(negedge RClk);
        check("single_ren", 32'(ren[0]), 32'h1);
        @(negedge RClk);
        check("single_ren_one_cycle", 32'({ren[0], vld[0]}), 0);
        @(negedge RClk);
        check("single_word", 32'({vld[0], chout[0], dout[0]}), 32'({1'b1, 2'd0, 8'hA5}));
        @(negedge RClk);
        check("single_back_idle", 32'({vld[0], busy[0]}), 0);

        // Burst limit: 4 words, re-arbitrate, then the last 2.
        do_reset();
        for (int d = 8'h10; d <= 8'h15; d++) push(0, 1, 8'(d));
        run_check(0, "burst", 100, 200);
        check("burst_reads", 32'(n_reads), 6);
        check("burst_words", 32'(acc_cyc.size()), 6);
        if (acc_cyc.size() == 6) begin
            for (int j = 1; j < 6; j++) begin
                check("burst_gap", 32'(acc_cyc[j] - acc_cyc[j-1]), (j == 4) ? 4 : 3);
                check("burst_chan", 32'(acc_ch[j]), 1);
            end
        end

        // Pure round-robin with BURST_LEN=1.
        do_reset();
        for (int w = 0; w < 2; w++) for (int ch = 0; ch < NF; ch++) push(1, ch, 8'($urandom));
        run_check(1, "rr", 100, 200);
        check("rr_words", 32'(acc_ch.size()), 8);
        if (acc_ch.size() == 8) begin
            for (int j = 0; j < 8; j++) check("rr_chan", 32'(acc_ch[j]), 32'(j % NF));
            for (int j = 1; j < 8; j++) check("rr_gap", 32'(acc_cyc[j] - acc_cyc[j-1]), 4);
        end

        // Backpressure.
        do_reset();
        rdy[0] = 1'b0;
        push(0, 3, 8'h3C);
        wait_vld(0, 10, ok);
        check("bp_valid_seen", 32'(ok), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge RClk);
            check("bp_hold", 32'({vld[0], chout[0], dout[0]}), 32'({1'b1, 2'd3, 8'h3C}));
            check("bp_no_read", 32'(ren[0]), 0);
        end
        rdy[0] = 1'b1;
        @(negedge RClk);
        check("bp_accepted", 32'({vld[0], busy[0]}), 0);

        // Enable mask excludes ch2.
        do_reset();
        en[0] = 4'b1011;
        for (int w = 0; w < 3; w++) for (int ch = 0; ch < NF; ch++) push(0, ch, 8'($urandom));
        run_check(0, "mask", 70, 400);
        for (int j = 0; j < acc_ch.size(); j++) check("mask_no_ch2", 32'(acc_ch[j] != 2), 1);
        check("mask_ch2_untouched", 32'(fill(0, 2)), 3);
        en[0] = '1;
        do_reset();
        run_check(0, "mask_drain", 100, 100);

        // Read suppressed by a flag going empty during READ.
        do_reset();
        rdy[0] = 1'b1;
        push(0, 1, 8'h5A);
        @(posedge RClk);
        #1 force_empty[0] = 4'b0010;
        push(0, 0, 8'hC0);
        push(0, 2, 8'hC2);
        @(negedge RClk);
        check("supp_no_read", 32'({ren[0], vld[0]}), 0);
        check("supp_in_read", 32'(busy[0]), 1);
        @(negedge RClk);
        check("supp_back_idle", 32'({busy[0], vld[0], ren[0]}), 0);
        force_empty[0] = '0;
        collect(0, 3, 40);
        if (got_q.size() == 3) begin
            check("supp_ptr_advanced", 32'(got_q[0]), 32'({2'd2, 8'hC2}));
            check("supp_next", 32'(got_q[1]), 32'({2'd0, 8'hC0}));
            check("supp_last", 32'(got_q[2]), 32'({2'd1, 8'h5A}));
        end

        // Randomised contents, masks and backpressure on both instances.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 2; k++) begin
                do_reset();
                en[k] = NF'($urandom);
                for (int ch = 0; ch < NF; ch++) begin
                    int n;
                    n = int'($urandom_range(7));
                    for (int w = 0; w < n; w++) push(k, ch, 8'($urandom));
                end
                run_check(k, "rand", 60, 3000);
                en[k] = '1;
                do_reset();
                run_check(k, "rand_drain", 100, 600);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end
endmodule
